// File: rtl/portfolio_variance.sv
// Portfolio variance engine: snapshots an N x N covariance matrix and weight vector, then
// accumulates w_i*w_j*cov_ij with one shared MAC and emits a saturated Q.FRACT result.
module portfolio_variance #(
  parameter int WIDTH     = 16,
  parameter int FRACT     = 8,
  parameter int N_STOCKS  = 4,
  parameter int ACC_WIDTH = 52
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid_in,
  input  logic [N_STOCKS*N_STOCKS*WIDTH-1:0]  cov_in,
  input  logic [N_STOCKS*WIDTH-1:0]           w_in,
  output logic                                ready_out,
  output logic                                valid_out,
  output logic [WIDTH-1:0]                    var_out,
  output logic                                sat_out
);

  localparam int IDX_W = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STOCKS - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Clamp limits expressed at accumulator width so the comparison is exact.
  localparam logic signed [ACC_WIDTH-1:0] R_MAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] R_MIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] cov_unpacked [N_STOCKS][N_STOCKS];
  logic signed [WIDTH-1:0] w_unpacked   [N_STOCKS];
  logic signed [WIDTH-1:0] cov_reg      [N_STOCKS][N_STOCKS];
  logic signed [WIDTH-1:0] w_reg        [N_STOCKS];

  logic [1:0]                  state_reg, state_next;
  logic [IDX_W-1:0]            i_reg, i_next;
  logic [IDX_W-1:0]            j_reg, j_next;
  logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic                        valid_reg, valid_next;
  logic [WIDTH-1:0]            var_reg, var_next;
  logic                        sat_reg, sat_next;
  logic                        load;

  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [3*WIDTH-1:0]   term;
  logic signed [ACC_WIDTH-1:0] term_ext;
  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    for (int a = 0; a < N_STOCKS; a++) begin
      w_unpacked[a] = w_in[a*WIDTH +: WIDTH];
      for (int b = 0; b < N_STOCKS; b++) begin
        cov_unpacked[a][b] = cov_in[(a*N_STOCKS+b)*WIDTH +: WIDTH];
      end
    end
  end

  // Weight pair product first, then the matrix entry: full 3*WIDTH precision, Q(3*FRACT).
  assign w_prod   = (2*WIDTH)'(w_reg[i_reg]) * (2*WIDTH)'(w_reg[j_reg]);
  assign term     = (3*WIDTH)'(w_prod) * (3*WIDTH)'(cov_reg[i_reg][j_reg]);
  assign term_ext = ACC_WIDTH'(term);
  assign shifted  = acc_reg >>> (2*FRACT);

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    acc_next   = acc_reg;
    valid_next = 1'b0;
    var_next   = var_reg;
    sat_next   = sat_reg;
    load       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (valid_in) begin
          load       = 1'b1;
          acc_next   = '0;
          i_next     = '0;
          j_next     = '0;
          state_next = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_next = acc_reg + term_ext;
        if (j_reg == LAST_IDX) begin
          j_next = '0;
          if (i_reg == LAST_IDX) begin
            i_next     = '0;
            state_next = ST_DONE;
          end else begin
            i_next = i_reg + 1'b1;
          end
        end else begin
          j_next = j_reg + 1'b1;
        end
      end
      ST_DONE: begin
        valid_next = 1'b1;
        state_next = ST_IDLE;
        if (shifted > R_MAX) begin
          var_next = OUT_MAX;
          sat_next = 1'b1;
        end else if (shifted < R_MIN) begin
          var_next = OUT_MIN;
          sat_next = 1'b1;
        end else begin
          var_next = shifted[WIDTH-1:0];
          sat_next = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      acc_reg   <= '0;
      valid_reg <= 1'b0;
      var_reg   <= '0;
      sat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      acc_reg   <= acc_next;
      valid_reg <= valid_next;
      var_reg   <= var_next;
      sat_reg   <= sat_next;
    end
  end

  // Snapshot is frozen from the accept edge until the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < N_STOCKS; a++) begin
        w_reg[a] <= '0;
        for (int b = 0; b < N_STOCKS; b++) begin
          cov_reg[a][b] <= '0;
        end
      end
    end else if (load) begin
      for (int a = 0; a < N_STOCKS; a++) begin
        w_reg[a] <= w_unpacked[a];
        for (int b = 0; b < N_STOCKS; b++) begin
          cov_reg[a][b] <= cov_unpacked[a][b];
        end
      end
    end
  end

  assign ready_out = (state_reg == ST_IDLE);
  assign valid_out = valid_reg;
  assign var_out   = var_reg;
  assign sat_out   = sat_reg;

endmodule
